// File: rtl/pipe_reg_stage.sv
// pipe_reg_stage: one-clock pipeline register with flush/bubble/hold control.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
`default_nettype none

module pipe_reg_stage #(
  parameter int STAGE  = 3,
  parameter int CTRL_W = 6,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int AUX_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_wd,
  input  logic              in_wreg,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [AUX_W-1:0]  in_aux,
  input  logic              perf_clr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_wd,
  output logic              out_wreg,
  output logic [DATA_W-1:0] out_wdata,
  output logic [AUX_W-1:0]  out_aux,
  output logic [CNT_W-1:0]  perf_bubble_cnt,
  output logic [CNT_W-1:0]  perf_hold_cnt
);

  logic w_s_here;
  logic w_s_next;
  logic w_kill;
  logic w_hold;
  logic w_unused;

  assign w_s_here = stall[STAGE];

  if (STAGE < CTRL_W-1) begin : g_has_next
    assign w_s_next = stall[STAGE+1];
  end else begin : g_last_stage
    assign w_s_next = 1'b0;
  end

  // Flush and bubble both load a NOP; hold only when nothing kills the slot.
  assign w_kill = flush | (w_s_here & ~w_s_next);
  assign w_hold = ~flush & w_s_here & w_s_next;

  // Only two stall bits are consumed; perf_clr is dead without the counters.
  assign w_unused = ^{stall, perf_clr};

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] wd_q,    wd_d;
  logic              wreg_q,  wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [AUX_W-1:0]  aux_q,   aux_d;

  always_comb begin
    valid_d = 1'b0;
    wd_d    = '0;
    wreg_d  = 1'b0;
    wdata_d = '0;
    aux_d   = '0;
    if (w_hold) begin
      valid_d = valid_q;
      wd_d    = wd_q;
      wreg_d  = wreg_q;
      wdata_d = wdata_q;
      aux_d   = aux_q;
    end else if (!w_kill && in_valid) begin
      valid_d = 1'b1;
      wd_d    = in_wd;
      wreg_d  = in_wreg;
      wdata_d = in_wdata;
      aux_d   = in_aux;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      aux_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      aux_q   <= aux_d;
    end
  end

  assign out_valid = valid_q;
  assign out_wd    = wd_q;
  assign out_wreg  = wreg_q;
  assign out_wdata = wdata_q;
  assign out_aux   = aux_q;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_max = {CNT_W{1'b1}};

  logic [CNT_W-1:0] bub_q, bub_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  always_comb begin
    bub_d  = bub_q;
    hold_d = hold_q;
    if (perf_clr) begin
      bub_d  = '0;
      hold_d = '0;
    end else begin
      if (w_kill && bub_q != c_max)  bub_d  = bub_q + c_one;
      if (w_hold && hold_q != c_max) hold_d = hold_q + c_one;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bub_q  <= '0;
      hold_q <= '0;
    end else begin
      bub_q  <= bub_d;
      hold_q <= hold_d;
    end
  end

  assign perf_bubble_cnt = bub_q;
  assign perf_hold_cnt   = hold_q;
`else
  assign perf_bubble_cnt = '0;
  assign perf_hold_cnt   = '0;
`endif

endmodule

`default_nettype wire

// File: doc/pipe_reg_stage.md
PIPE_REG_STAGE -- requirements
Module: pipe_reg_stage

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- STAGE, 3, index of this stage's bit in the stall vector
- CTRL_W, 6, stall vector width
- ADDR_W, 5, destination register address width
- DATA_W, 32, write-data width
- AUX_W, 8, side-band control width (opcode, sub-op)
- CNT_W, 16, performance counter width
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge
- rst, in, 1, asynchronous, active-low reset
- stall, in, CTRL_W, pipeline stall vector from ctrl
- flush, in, 1, kill the stage contents
- in_valid, in, 1, upstream slot holds a real instruction
- in_wd, in, ADDR_W, destination register address
- in_wreg, in, 1, register write enable
- in_wdata, in, DATA_W, write data
- in_aux, in, AUX_W, side-band control
- perf_clr, in, 1, synchronous clear of the performance counters
- out_valid, out, 1, registered valid
- out_wd, out, ADDR_W, registered address
- out_wreg, out, 1, registered write enable
- out_wdata, out, DATA_W, registered data
- out_aux, out, AUX_W, registered side-band
- perf_bubble_cnt, out, CNT_W, count of bubble and flush cycles
- perf_hold_cnt, out, CNT_W, count of hold cycles

Function
REQ-003 The stage SHALL have a latency of one clock: inputs captured on edge N appear on the outputs after edge N.
REQ-004 Definitions: s_here = stall[STAGE]; s_next = stall[STAGE+1] when STAGE < CTRL_W-1, else 0.
REQ-005 Action priority per edge SHALL be: FLUSH (flush=1) > BUBBLE (s_here=1, s_next=0) > HOLD (s_here=1, s_next=1) > ADVANCE (s_here=0).
REQ-006 FLUSH and BUBBLE SHALL load the NOP state: out_valid=0, out_wd=0, out_wreg=0, out_wdata=0, out_aux=0.
REQ-007 HOLD SHALL keep every output register unchanged.
REQ-008 ADVANCE with in_valid=1 SHALL capture in_wd, in_wreg, in_wdata, in_aux and set out_valid=1.
REQ-009 ADVANCE with in_valid=0 SHALL load the NOP state, so out_wreg is never 1 while out_valid is 0.
REQ-010 s_here=0 with s_next=1 is not a legal stall pattern; the stage SHALL treat it as ADVANCE, with no other side effect.
REQ-011 Flush during HOLD SHALL win: the held contents are discarded on that edge.
REQ-012 The stage SHALL expose no combinational path from any input to any output.

Reset
REQ-013 With rst=0, all outputs SHALL go to 0 asynchronously, counters included.
REQ-014 Reset asserted mid-hold or mid-flush SHALL discard the stage contents; no captured value survives reset.
REQ-015 On the first rising edge after rst deasserts, the stage SHALL apply the normal priority rules of REQ-005.

Configuration
REQ-016 Macro PIPE_PERF_CNT_EN SHALL control the performance counters.
- Defined: perf_bubble_cnt increments by 1 on each FLUSH or BUBBLE edge, and perf_hold_cnt increments by 1 on each HOLD edge.
- Both counters saturate at 2^CNT_W-1.
- perf_clr=1 zeroes both counters on the edge and takes priority over increment.
- Not defined: no counter flops are built, both counter outputs are tied to 0, and perf_clr is ignored.
- The ports SHALL be present in both builds.

Verification
REQ-017 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset then ADVANCE: in_valid=1, wd=5'h1F, wreg=1, wdata=32'hDEADBEEF, aux=8'hA5 -> outputs show exactly those values after one edge, with out_valid=1.
- HOLD: load 32'h12345678, then hold 3 cycles with stall=6'b011000 while inputs change -> outputs stay 32'h12345678; with the macro defined, perf_hold_cnt=3.
- BUBBLE: stall=6'b001000 for one edge -> NOP state; perf_bubble_cnt increments by 1.
- Flush priority: stall=6'b011000 with flush=1 and out_valid=1 -> NOP state after the edge.
- Async reset: drop rst mid-cycle while out_wdata=32'hCAFEF00D -> all outputs 0 before the next edge.
- Saturation: CNT_W=4, 20 consecutive BUBBLE edges -> perf_bubble_cnt=4'hF; perf_clr=1 together with a bubble -> 0.
- Without the macro: repeat the hold and bubble scenarios -> both counters read 0.
